// File: rtl/spectrum_peak_finder.sv
// Purpose: find the two strongest bins (power re*re + im*im) of each N-bin spectrum frame.
// Latency: result valid 3 edges after the edge that transfers bin N-1; one frame result in flight.
// Backpressure: s_ready is low from the last bin until the result is taken; results hold while m_ready=0.
//
// Ports:
//   ap_clk, ap_rst_n       clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready        input bin handshake; s_re/s_im signed W-bit bin, s_last marks bin N-1
//   m_valid/m_ready        result handshake
//   pk1_bin/pk1_pow        index and unsigned 2W-bit power of the largest bin
//   pk2_bin/pk2_pow        index and power of the second-largest bin
//   frame_err              sticky: s_last disagreed with the internal bin count in this frame
//   busy                   frame partially received, draining, or result pending
module spectrum_peak_finder #(
  parameter int N       = 256,
  parameter int W       = 16,
  parameter bit SKIP_DC = 1'b0
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [W-1:0]    s_re,
  input  logic signed [W-1:0]    s_im,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(N)-1:0]   pk1_bin,
  output logic [2*W-1:0]         pk1_pow,
  output logic [$clog2(N)-1:0]   pk2_bin,
  output logic [2*W-1:0]         pk2_pow,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int LB = $clog2(N);
  localparam int PW = 2 * W;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam logic [LB-1:0] K_LAST = LB'(N - 1);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [LB-1:0] k_q, k_d;
  logic          err_q, err_d;
  // Holds s_ready low during reset and until the first edge after release.
  logic          rdy_en_q;

  // ---------------------------------------------------------------------------
  // Power pipeline
  // ---------------------------------------------------------------------------
  logic          s1_vld_q;
  logic [LB-1:0] s1_bin_q;
  logic [PW-1:0] s1_sq_re_q;
  logic [PW-1:0] s1_sq_im_q;

  logic          s2_vld_q;
  logic [LB-1:0] s2_bin_q;
  logic [PW-1:0] s2_pow_q;

  // ---------------------------------------------------------------------------
  // Peak registers
  // ---------------------------------------------------------------------------
  logic [LB-1:0] pk1_bin_q, pk1_bin_d;
  logic [PW-1:0] pk1_pow_q, pk1_pow_d;
  logic [LB-1:0] pk2_bin_q, pk2_bin_d;
  logic [PW-1:0] pk2_pow_q, pk2_pow_d;

  logic xfer;
  logic out_hs;
  logic k_is_last;
  logic dc_masked;

  logic signed [PW-1:0] re_x;
  logic signed [PW-1:0] im_x;
  logic signed [PW-1:0] sq_re;
  logic signed [PW-1:0] sq_im;

  assign s_ready   = rdy_en_q && (state_q == ST_ACC);
  assign xfer      = s_valid && s_ready;
  assign m_valid   = (state_q == ST_OUT);
  assign out_hs    = m_valid && m_ready;
  assign k_is_last = (k_q == K_LAST);

  // Squares are formed at full 2W width; each is at most 2^(2W-2), so the
  // truncating multiply is exact and the later sum fits in 2W unsigned bits.
  assign re_x  = PW'(s_re);
  assign im_x  = PW'(s_im);
  assign sq_re = re_x * re_x;
  assign sq_im = im_x * im_x;

  // ---------------------------------------------------------------------------
  // Frame FSM. The bin counter alone decides the frame end; s_last is only
  // cross-checked against it. FLUSH waits for the final bin to leave both
  // pipeline stages (it reaches the peak registers on the second FLUSH edge),
  // so OUT is entered on the third edge after the last transfer.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = err_q;
    case (state_q)
      ST_ACC: begin
        if (xfer) begin
          k_d = k_q + LB'(1);
          if (s_last != k_is_last) begin
            err_d = 1'b1;
          end
          if (k_is_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (!s1_vld_q && !s2_vld_q) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_hs) begin
          state_d = ST_ACC;
          k_d     = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACC;
        k_d     = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= ST_ACC;
      k_q      <= '0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: register both squares with the bin tag.
  // Stage 2: register the sum.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_bin_q   <= '0;
      s1_sq_re_q <= '0;
      s1_sq_im_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_bin_q   <= '0;
      s2_pow_q   <= '0;
    end else begin
      s1_vld_q <= xfer;
      if (xfer) begin
        s1_bin_q   <= k_q;
        s1_sq_re_q <= sq_re;
        s1_sq_im_q <= sq_im;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_bin_q <= s1_bin_q;
        s2_pow_q <= s1_sq_re_q + s1_sq_im_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: peak tracking. Strict compares keep the earlier (lower) bin on
  // ties, and a zero-power bin can never displace the (0,0) start values.
  // The handshake that releases a result also seeds the next frame; the
  // pipeline is empty in OUT, so the two branches never compete.
  // ---------------------------------------------------------------------------
  assign dc_masked = SKIP_DC && (s2_bin_q == '0);

  always_comb begin
    pk1_bin_d = pk1_bin_q;
    pk1_pow_d = pk1_pow_q;
    pk2_bin_d = pk2_bin_q;
    pk2_pow_d = pk2_pow_q;
    if (out_hs) begin
      pk1_bin_d = '0;
      pk1_pow_d = '0;
      pk2_bin_d = '0;
      pk2_pow_d = '0;
    end else if (s2_vld_q && !dc_masked) begin
      if (s2_pow_q > pk1_pow_q) begin
        pk2_bin_d = pk1_bin_q;
        pk2_pow_d = pk1_pow_q;
        pk1_bin_d = s2_bin_q;
        pk1_pow_d = s2_pow_q;
      end else if (s2_pow_q > pk2_pow_q) begin
        pk2_bin_d = s2_bin_q;
        pk2_pow_d = s2_pow_q;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pk1_bin_q <= '0;
      pk1_pow_q <= '0;
      pk2_bin_q <= '0;
      pk2_pow_q <= '0;
    end else begin
      pk1_bin_q <= pk1_bin_d;
      pk1_pow_q <= pk1_pow_d;
      pk2_bin_q <= pk2_bin_d;
      pk2_pow_q <= pk2_pow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The peak registers and frame_err do not move while in OUT, so
  // the result stays stable under backpressure without extra holding logic.
  // ---------------------------------------------------------------------------
  assign pk1_bin   = pk1_bin_q;
  assign pk1_pow   = pk1_pow_q;
  assign pk2_bin   = pk2_bin_q;
  assign pk2_pow   = pk2_pow_q;
  assign frame_err = err_q;
  assign busy      = (k_q != '0) || (state_q != ST_ACC);

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Purpose: self-checking bench for spectrum_peak_finder (default and SKIP_DC=1 instances).
// Latency: checks result timing relative to the last-bin transfer edge.
// Backpressure: holds m_ready low in OUT and toggles s_valid to confirm no transfers.
module tb_spectrum_peak_finder;

  localparam int N  = 256;
  localparam int W  = 16;
  localparam int LB = 8;
  localparam int PW = 32;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic ap_rst_n;
  logic s_valid, s_valid2, s_last, m_ready, m_ready2;
  logic signed [W-1:0] s_re, s_im;

  logic s_ready, m_valid, frame_err, busy;
  logic [LB-1:0] pk1_bin, pk2_bin;
  logic [PW-1:0] pk1_pow, pk2_pow;

  logic s_ready2, m_valid2, frame_err2, busy2;
  logic [LB-1:0] pk1_bin2, pk2_bin2;
  logic [PW-1:0] pk1_pow2, pk2_pow2;

  spectrum_peak_finder #(.N(N), .W(W), .SKIP_DC(1'b0)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .pk1_bin(pk1_bin), .pk1_pow(pk1_pow), .pk2_bin(pk2_bin), .pk2_pow(pk2_pow),
    .frame_err(frame_err), .busy(busy)
  );

  spectrum_peak_finder #(.N(N), .W(W), .SKIP_DC(1'b1)) dut_dc (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready2),
    .pk1_bin(pk1_bin2), .pk1_pow(pk1_pow2), .pk2_bin(pk2_bin2), .pk2_pow(pk2_pow2),
    .frame_err(frame_err2), .busy(busy2)
  );

  // Frame stimulus: up to two non-zero bins, all other bins zero, plus the
  // expected result. A bin index of -1 means "unused"; last_at=-1 means s_last never set.
  typedef struct {
    int b1; int re1; int im1;
    int b2; int re2; int im2;
    int last_at;
    int e1b; logic [PW-1:0] e1p;
    int e2b; logic [PW-1:0] e2p;
    logic eerr;
  } vec_t;

  typedef struct {
    int b1; logic [PW-1:0] p1;
    int b2; logic [PW-1:0] p2;
    logic err;
  } res_t;

  res_t exp_q[$];
  res_t exp_q2[$];
  res_t mon_e, mon_e2;
  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_done2 = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_res(input string tag, input res_t e,
                           input logic [LB-1:0] b1, input logic [PW-1:0] p1,
                           input logic [LB-1:0] b2, input logic [PW-1:0] p2,
                           input logic er);
    chk({tag, ".pk1_bin"}, 64'(b1), 64'(e.b1));
    chk({tag, ".pk1_pow"}, 64'(p1), 64'(e.p1));
    chk({tag, ".pk2_bin"}, 64'(b2), 64'(e.b2));
    chk({tag, ".pk2_pow"}, 64'(p2), 64'(e.p2));
    chk({tag, ".frame_err"}, 64'(er), 64'(e.err));
  endtask

  // Scoreboard consumers: compare on each result handshake.
  always @(negedge ap_clk) begin
    if (ap_rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: m_valid with no frame outstanding, pk1_bin=%0d (t=%0t)",
                 pk1_bin, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check_res("res", mon_e, pk1_bin, pk1_pow, pk2_bin, pk2_pow, frame_err);
        n_done++;
      end
    end
  end

  always @(negedge ap_clk) begin
    if (ap_rst_n && m_valid2 && m_ready2) begin
      if (exp_q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_dc: m_valid with no frame outstanding (t=%0t)", $time);
      end else begin
        mon_e2 = exp_q2.pop_front();
        check_res("res_dc", mon_e2, pk1_bin2, pk1_pow2, pk2_bin2, pk2_pow2, frame_err2);
        n_done2++;
      end
    end
  end

  // Drive nbins bins of a frame; a full frame pushes its expected result.
  // Returns 1 ns after the edge that transferred the final driven bin.
  task automatic send_frame(input vec_t v, input bit sel, input int nbins, input bit bubbles);
    res_t r;
    if (nbins == N) begin
      r = '{v.e1b, v.e1p, v.e2b, v.e2p, v.eerr};
      if (sel) exp_q2.push_back(r);
      else     exp_q.push_back(r);
    end
    for (int i = 0; i < nbins; i++) begin
      int guard;
      guard = 0;
      @(negedge ap_clk);
      if (bubbles && ($urandom_range(0, 3) == 0)) begin
        s_valid  = 1'b0;
        s_valid2 = 1'b0;
        @(negedge ap_clk);
      end
      s_re   = (i == v.b1) ? W'(v.re1) : ((i == v.b2) ? W'(v.re2) : '0);
      s_im   = (i == v.b1) ? W'(v.im1) : ((i == v.b2) ? W'(v.im2) : '0);
      s_last = (i == v.last_at);
      if (sel) s_valid2 = 1'b1;
      else     s_valid  = 1'b1;
      while (!(sel ? s_ready2 : s_ready)) begin
        @(negedge ap_clk);
        guard++;
        if (guard > 2000) begin
          checks++;
          errors++;
          $display("FAIL s_ready_timeout: bin %0d never accepted within %0d cycles", i, guard);
          s_valid  = 1'b0;
          s_valid2 = 1'b0;
          return;
        end
      end
      @(posedge ap_clk);
    end
    #1;
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
    s_last   = 1'b0;
  endtask

  task automatic wait_done(input int want, input bit sel);
    int guard;
    guard = 0;
    while ((sel ? n_done2 : n_done) < want) begin
      @(negedge ap_clk);
      guard++;
      if (guard > 3000) begin
        checks++;
        errors++;
        $display("FAIL result_timeout: got %0d results, expected %0d", sel ? n_done2 : n_done, want);
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    vec_t dct[2];
    vec_t tone2;
    int lat;
    int guard;
    int expect_done;

    //            b1  re1    im1    b2  re2  im2  last  e1b  e1p            e2b e2p        err
    tbl[0] = '{13,  100,     0,    -1,   0,   0, 255,  13, 32'd10000,      0, 32'd0,     1'b0};
    tbl[1] = '{13,  128,     0,    40,  64,   0, 255,  13, 32'd16384,     40, 32'd4096,  1'b0};
    tbl[2] = '{ 5,   20,     0,     9,  20,   0, 255,   5, 32'd400,        9, 32'd400,   1'b0};
    tbl[3] = '{ 7, -32768, -32768, -1,   0,   0, 255,   7, 32'h8000_0000,  0, 32'd0,     1'b0};
    tbl[4] = '{13,  100,     0,    -1,   0,   0, 100,  13, 32'd10000,      0, 32'd0,     1'b1};
    tbl[5] = '{ 3,    3,     4,   200, -300, 400, 255, 200, 32'd250000,    3, 32'd25,    1'b0};
    tbl[6] = '{ 0,    5,     0,    -1,   0,   0, 255,   0, 32'd25,         0, 32'd0,     1'b0};
    tbl[7] = '{10,   50,     0,    20,  30,   0, 255,  10, 32'd2500,      20, 32'd900,   1'b0};
    tbl[8] = '{-1,    0,     0,    -1,   0,   0, 255,   0, 32'd0,          0, 32'd0,     1'b0};
    tbl[9] = '{60,    0,    -7,    61,   7,   0,  -1,  60, 32'd49,        61, 32'd49,    1'b1};

    dct[0] = '{ 0, 1000,     0,     3,  10,   0, 255,   3, 32'd100,        0, 32'd0,     1'b0};
    dct[1] = '{ 0, 1000,     0,    -1,   0,   0, 255,   0, 32'd0,          0, 32'd0,     1'b0};

    ap_rst_n = 1'b0;
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
    s_last   = 1'b0;
    s_re     = '0;
    s_im     = '0;
    m_ready  = 1'b1;
    m_ready2 = 1'b1;

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst.s_ready", 64'(s_ready), 0);
    chk("rst.m_valid", 64'(m_valid), 0);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.frame_err", 64'(frame_err), 0);
    chk("rst.pk1_pow", 64'(pk1_pow), 0);
    chk("rst.pk2_bin", 64'(pk2_bin), 0);

    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("rel.s_ready_before_edge", 64'(s_ready), 0);
    @(posedge ap_clk);
    #1;
    chk("rel.s_ready_after_edge", 64'(s_ready), 1);

    // Two-tone frame: latency from the last transfer to m_valid
    send_frame(tbl[1], 1'b0, N, 1'b0);
    chk("flush.busy", 64'(busy), 1);
    chk("flush.s_ready", 64'(s_ready), 0);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge ap_clk);
      #1;
      if (m_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency_edges", 64'(lat), 3);
    wait_done(1, 1'b0);
    expect_done = 1;

    // Table-driven frames, back to back, some with input bubbles
    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i], 1'b0, N, (i % 2) == 1);
    end
    expect_done += 10;
    wait_done(expect_done, 1'b0);

    // Backpressure in OUT with s_valid toggling
    tone2 = tbl[2];
    @(posedge ap_clk);
    #1;
    m_ready = 1'b0;
    send_frame(tone2, 1'b0, N, 1'b0);
    guard = 0;
    while (!m_valid && guard < 20) begin
      @(negedge ap_clk);
      guard++;
    end
    chk("bp.m_valid_seen", 64'(m_valid), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      s_valid = (c % 2) == 0;
      s_re    = W'($urandom_range(1, 1000));
      s_im    = '0;
      chk("bp.m_valid", 64'(m_valid), 1);
      chk("bp.s_ready", 64'(s_ready), 0);
      chk("bp.busy", 64'(busy), 1);
      chk("bp.pk1_bin", 64'(pk1_bin), 64'(tone2.e1b));
      chk("bp.pk2_pow", 64'(pk2_pow), 64'(tone2.e2p));
    end
    @(negedge ap_clk);
    s_valid = 1'b0;
    s_re    = '0;
    @(posedge ap_clk);
    #1;
    m_ready = 1'b1;
    expect_done += 1;
    wait_done(expect_done, 1'b0);
    // A following frame must be intact if nothing slipped in during OUT
    send_frame(tbl[0], 1'b0, N, 1'b0);
    expect_done += 1;
    wait_done(expect_done, 1'b0);
    @(negedge ap_clk);
    chk("idle.busy", 64'(busy), 0);

    // Reset in the middle of a frame, then a clean two-tone frame
    send_frame(tbl[1], 1'b0, 50, 1'b0);
    chk("mid.busy", 64'(busy), 1);
    chk("mid.pk1_pow", 64'(pk1_pow), 16384);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst.s_ready", 64'(s_ready), 0);
    chk("midrst.busy", 64'(busy), 0);
    chk("midrst.m_valid", 64'(m_valid), 0);
    chk("midrst.pk1_pow", 64'(pk1_pow), 0);
    chk("midrst.pk1_bin", 64'(pk1_bin), 0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("midrel.s_ready_before_edge", 64'(s_ready), 0);
    @(posedge ap_clk);
    #1;
    chk("midrel.s_ready_after_edge", 64'(s_ready), 1);
    send_frame(tbl[1], 1'b0, N, 1'b0);
    expect_done += 1;
    wait_done(expect_done, 1'b0);
    repeat (5) @(negedge ap_clk);
    chk("post.queue_empty", 64'(exp_q.size()), 0);

    // SKIP_DC instance
    for (int i = 0; i < 2; i++) begin
      send_frame(dct[i], 1'b1, N, 1'b0);
    end
    wait_done(2, 1'b1);
    chk("dc.queue_empty", 64'(exp_q2.size()), 0);

    repeat (3) @(negedge ap_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_finder.md
SPECTRUM_PEAK_FINDER -- requirements
Module: spectrum_peak_finder

Interface
REQ-001 SHALL have parameter N, default 256: bins per frame; power of 2, 4..4096.
REQ-002 SHALL have parameter W, default 16: signed two's-complement width of each bin component (Q8.8 at W=16).
REQ-003 SHALL have parameter SKIP_DC, default 0: 1 = bin 0 excluded from peak search.
REQ-004 SHALL have a single clock and an asynchronous active-low reset, as listed first below.
REQ-005 Ports (name direction width meaning):
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input bin valid.
- s_ready  out  1  block accepts input bin.
- s_re  in  W  bin real part, signed.
- s_im  in  W  bin imaginary part, signed.
- s_last  in  1  producer marks bin N-1.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts result.
- pk1_bin  out  log2(N)  bin index of largest power.
- pk1_pow  out  2W  power of largest bin, unsigned.
- pk2_bin  out  log2(N)  bin index of second-largest power.
- pk2_pow  out  2W  power of second-largest bin, unsigned.
- frame_err  out  1  s_last misaligned within the frame.
- busy  out  1  frame in progress or result pending.

Function
REQ-006 A transfer SHALL occur only on a rising edge with s_valid=1 and s_ready=1.
REQ-007 States SHALL be ACC, FLUSH and OUT; s_ready=1 only in ACC; m_valid=1 only in OUT.
REQ-008 An internal bin counter k SHALL start at 0, increment per transfer and tag each bin; the counter, not s_last, defines frame end.
REQ-009 ACC->FLUSH SHALL occur on the transfer with k=N-1; FLUSH SHALL last exactly 2 cycles; FLUSH->OUT then.
REQ-010 Power SHALL be re*re + im*im, computed in 2W-bit unsigned arithmetic without saturation (max 2^(2W-1) fits).
REQ-011 Power pipeline: stage 1 registers both squares; stage 2 registers the sum; stage 3 updates the peak registers.
REQ-012 Latency: transfer of bin N-1 at edge t -> m_valid=1 after edge t+3.
REQ-013 Peak update, bin p with power P: if P > pk1_pow then pk2 <= pk1 and pk1 <= (p,P); else if P > pk2_pow then pk2 <= (p,P); otherwise no change.
REQ-014 Comparisons SHALL be strict, so the lower bin index wins ties.
REQ-015 At frame start, the peak registers SHALL be pk1/pk2 = (bin 0, pow 0); a bin with power 0 never displaces them.
REQ-016 With SKIP_DC=1, bin 0 SHALL NOT update the peak registers but SHALL count toward N.
REQ-017 frame_err SHALL be sticky per frame and set when s_last=1 at k!=N-1, or s_last=0 at k=N-1.
REQ-018 In OUT, all result outputs SHALL be held stable until m_valid and m_ready are both 1.
REQ-019 On handshake in OUT: next state ACC; k, the peak registers and frame_err cleared for the next frame.
REQ-020 busy SHALL be 1 when k!=0 or state!=ACC.

Reset
REQ-021 ap_rst_n=0 SHALL immediately force state=ACC, k=0, all peak registers 0, frame_err=0, m_valid=0, busy=0, pipeline valid bits 0.
REQ-022 Reset mid-frame SHALL discard the partial frame; no result is emitted for it.
REQ-023 s_ready SHALL be 0 while ap_rst_n=0 and SHALL be 1 from the first edge after release.

Verification
REQ-024 Single bin: bin 13 re=100, im=0, all others 0 -> pk1=(13,10000), pk2=(0,0), frame_err=0.
REQ-025 Two tones: bin 13 re=128, bin 40 re=64, others 0 -> pk1=(13,16384), pk2=(40,4096); m_valid exactly 3 edges after bin 255 transfer.
REQ-026 Tie plus extreme: bins 5 and 9 both re=20 (power 400) -> pk1=(5,400), pk2=(9,400); bin 7 re=im=-32768 -> pk1=(7,2147483648).
REQ-027 Backpressure: m_ready=0 for 10 cycles in OUT -> m_valid held, outputs stable, s_ready=0; s_valid toggling during OUT causes no transfers.
REQ-028 Framing: s_last at bin 100 -> frame still ends at bin 255, frame_err=1; SKIP_DC=1 with bin 0 re=1000 and bin 3 re=10 -> pk1=(3,100).
REQ-029 Reset at bin 50, release, then a clean two-tone frame -> result identical to REQ-025 and no spurious m_valid.
